// File: rtl/keypad_scan_debounce.sv
// 3x4 matrix keypad scanner: rotates an active-low column, debounces presses and releases,
// and reports one key event per press. Define KEYPAD_REPEAT_EN for auto-repeat while held.
module keypad_scan_debounce #(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 3,
    parameter int REPEAT_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [2:0] column,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    // state    | meaning
    // SCAN     | rotating columns, looking for a single-row press
    // DEBOUNCE | column frozen, counting ticks the latched pattern stays stable
    // HELD     | key accepted and still down
    // RELEASE  | counting no-key ticks before the scan resumes
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               FAST_DEB = (DEBOUNCE_CNT <= 1);

    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_TICKS < 1) begin : g_param_check
        $error("keypad_scan_debounce: illegal parameter set");
    end

    logic [3:0]       sync1_q, sync2_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_q, col_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       lat_row_q, lat_row_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;

    logic             tick;
    logic             row_ok;
    logic             row_same;
    logic [1:0]       col_next;
    logic [CNT_W-1:0] cnt_inc;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_TICKS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS);
    logic [REP_W-1:0] rep_q, rep_d;
    logic [REP_W-1:0] rep_inc;
    assign rep_inc = rep_q + REP_W'(1);
`endif

    function automatic logic [3:0] key_map(input logic [1:0] c, input logic [3:0] pat);
        logic [3:0] code;
        code = 4'h0;
        case (pat)
            4'b0111: code = 4'd1 + {2'b00, c};
            4'b1011: code = 4'd4 + {2'b00, c};
            4'b1101: code = 4'd7 + {2'b00, c};
            4'b1110: code = (c == 2'd0) ? 4'hE : ((c == 2'd1) ? 4'h0 : 4'hF);
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    assign tick     = (div_q == DIV_LAST);
    assign row_same = (sync2_q == lat_row_q);
    assign col_next = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
    assign cnt_inc  = cnt_q + CNT_ONE;

    // Patterns with zero or several low rows are treated exactly like no key.
    always_comb begin
        row_ok = 1'b0;
        case (sync2_q)
            4'b0111, 4'b1011, 4'b1101, 4'b1110: row_ok = 1'b1;
            default:                            row_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        div_d       = tick ? '0 : div_q + DIV_W'(1);
        col_d       = col_q;
        cnt_d       = cnt_q;
        lat_row_d   = lat_row_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_d       = rep_q;
`endif
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (row_ok) begin
                        lat_row_d = sync2_q;
                        cnt_d     = CNT_ONE;
                        if (FAST_DEB) begin
                            state_d     = HELD;
                            key_valid_d = 1'b1;
                            key_code_d  = key_map(col_q, sync2_q);
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        col_d = col_next;
                    end
                end
                DEBOUNCE: begin
                    if (row_same) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= CNT_LAST) begin
                            state_d     = HELD;
                            key_valid_d = 1'b1;
                            key_code_d  = key_map(col_q, lat_row_q);
                        end
                    end else begin
                        state_d = SCAN;
                        col_d   = col_next;
                    end
                end
                HELD: begin
                    if (!row_same) begin
                        if (FAST_DEB && !row_ok) begin
                            state_d = SCAN;
                            col_d   = col_next;
                        end else begin
                            state_d = RELEASE;
                            cnt_d   = CNT_ONE;
                        end
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rep_inc >= REP_LAST) begin
                        rep_d       = '0;
                        key_valid_d = 1'b1;
                    end else begin
                        rep_d = rep_inc;
                    end
`endif
                end
                RELEASE: begin
                    if (row_same) begin
                        state_d = HELD;
                    end else if (!row_ok) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= CNT_LAST) begin
                            state_d = SCAN;
                            col_d   = col_next;
                        end
                    end else begin
                        // a different key while letting go is bounce: restart the release count
                        cnt_d = CNT_ONE;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
`ifdef KEYPAD_REPEAT_EN
        if (state_d != HELD || state_q != HELD) begin
            rep_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= 4'b0000;
            sync2_q     <= 4'b0000;
            div_q       <= '0;
            col_q       <= 2'd0;
            state_q     <= SCAN;
            cnt_q       <= '0;
            lat_row_q   <= 4'b0000;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            sync1_q     <= row;
            sync2_q     <= sync1_q;
            div_q       <= div_d;
            col_q       <= col_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_row_q   <= lat_row_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`endif

    always_comb begin
        case (col_q)
            2'd0:    column = 3'b110;
            2'd1:    column = 3'b101;
            2'd2:    column = 3'b011;
            default: column = 3'b110;
        endcase
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = (state_q == HELD) || (state_q == RELEASE);

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Self-checking bench for keypad_scan_debounce: directed scenarios plus random row
// sequences compared cycle by cycle against a tick-level behavioural model.
module tb_keypad_scan_debounce;
    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;
    localparam int REPEAT_TICKS = 8;
`ifdef KEYPAD_REPEAT_EN
    localparam int EXP_REP_PULSES = 4;
    localparam int EXP_REP_SPAN   = 3 * REPEAT_TICKS * SCAN_DIV;
`else
    localparam int EXP_REP_PULSES = 1;
    localparam int EXP_REP_SPAN   = 0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] row;
    logic [2:0] column;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int n_checks = 0;
    int n_fail   = 0;

    keypad_scan_debounce #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT),
        .REPEAT_TICKS (REPEAT_TICKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .column    (column),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model (per scan tick) ----------------
    localparam int M_SCAN = 0, M_CONFIRM = 1, M_DOWN = 2, M_UP = 3;
    logic [3:0] code_tab [0:11] = '{4'hE, 4'h0, 4'hF, 4'h7, 4'h8, 4'h9,
                                    4'h4, 4'h5, 4'h6, 4'h1, 4'h2, 4'h3};
    int         m_edges, m_mode, m_col, m_stable, m_quiet, m_rep, m_r;
    logic [3:0] m_h1, m_h2, m_samp, m_pat, m_code;
    logic       m_valid, m_held, m_good, m_tick;
    logic [2:0] m_column;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_edges = 0; m_mode = M_SCAN; m_col = 0; m_stable = 0; m_quiet = 0; m_rep = 0;
            m_h1 = 4'b0000; m_h2 = 4'b0000; m_pat = 4'b0000; m_code = 4'h0; m_valid = 1'b0;
        end else begin
            m_samp  = m_h2;
            m_h2    = m_h1;
            m_h1    = row;
            m_tick  = (m_edges % SCAN_DIV) == (SCAN_DIV - 1);
            m_edges = m_edges + 1;
            m_valid = 1'b0;
            m_good  = ($countones(~m_samp) == 1);
            if (m_tick) begin
                if (m_mode == M_SCAN || m_mode == M_CONFIRM) begin
                    if (m_mode == M_SCAN && m_good) begin
                        m_pat = m_samp; m_stable = 1; m_mode = M_CONFIRM;
                    end else if (m_mode == M_CONFIRM && m_samp == m_pat) begin
                        m_stable = m_stable + 1;
                    end else begin
                        m_mode = M_SCAN; m_col = (m_col + 1) % 3;
                    end
                    if (m_mode == M_CONFIRM && m_stable >= DEBOUNCE_CNT) begin
                        for (int i = 0; i < 4; i++) if (!m_pat[i]) m_r = i;
                        m_code = code_tab[m_r * 3 + m_col];
                        m_valid = 1'b1; m_mode = M_DOWN; m_rep = 0;
                    end
                end else if (m_samp == m_pat) begin
                    if (m_mode == M_DOWN) begin
`ifdef KEYPAD_REPEAT_EN
                        m_rep = m_rep + 1;
                        if (m_rep == REPEAT_TICKS) begin m_valid = 1'b1; m_rep = 0; end
`endif
                    end else begin
                        m_mode = M_DOWN; m_rep = 0;
                    end
                end else begin
                    m_quiet = (m_mode == M_UP && !m_good) ? m_quiet + 1 : 1;
                    m_mode  = M_UP; m_rep = 0;
                    if (!m_good && m_quiet >= DEBOUNCE_CNT) begin
                        m_mode = M_SCAN; m_col = (m_col + 1) % 3;
                    end
                end
            end
        end
        m_held   = (m_mode == M_DOWN) || (m_mode == M_UP);
        m_column = 3'b111 ^ (3'b001 << m_col);
    end

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic hold(input logic [3:0] r, input int cycles, output int pulses,
                        output logic [3:0] code, output int mm, output int first_at,
                        output int last_at, output int dbl);
        logic prev_v;
        pulses = 0; mm = 0; first_at = 0; last_at = 0; dbl = 0; code = key_code; prev_v = key_valid;
        row = r;
        for (int i = 1; i <= cycles; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                pulses++; code = key_code; last_at = i;
                if (first_at == 0) first_at = i;
                if (prev_v === 1'b1) dbl++;
            end
            prev_v = key_valid;
            if (key_valid !== m_valid || key_code !== m_code || key_held !== m_held ||
                column !== m_column) mm++;
        end
    endtask

    task automatic wait_col(input logic [2:0] want, output bit ok);
        logic [2:0] prev;
        ok = 1'b0; prev = column;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (column == want && prev != want) ok = 1'b1;
            prev = column;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [2:0] exp_col;
        rst = 1'b0; row = 4'b0000;
        repeat (2) @(negedge clk);
        n_checks++;
        if (column !== 3'b110 || key_valid !== 1'b0 || key_code !== 4'h0 || key_held !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: col=%b valid=%b code=%h held=%b, want col=110 valid=0 code=0 held=0",
                     column, key_valid, key_code, key_held);
        end
        rst = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_col = 3'b111 ^ (3'b001 << ((k / SCAN_DIV) % 3));
            n_checks++;
            if (column !== exp_col) begin
                n_fail++;
                $display("FAIL reset_rotation cycle %0d: column=%b want %b", k, column, exp_col);
            end
        end
    endtask

    task automatic test_clean_press();
        bit ok; int p, mm, f, l, d; logic [3:0] c;
        wait_col(3'b101, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL press_wait_col: column 101 never reached"); end
        hold(4'b0111, 20, p, c, mm, f, l, d);
        n_checks++;
        if (p !== 1 || c !== 4'h2) begin
            n_fail++; $display("FAIL press_event: pulses=%0d code=%h, want 1 pulse code=2", p, c);
        end
        n_checks++;
        if (f !== DEBOUNCE_CNT * SCAN_DIV) begin
            n_fail++; $display("FAIL press_latency: pulse at cycle %0d, want %0d", f, DEBOUNCE_CNT * SCAN_DIV);
        end
        n_checks++;
        if (key_held !== 1'b1 || column !== 3'b101) begin
            n_fail++; $display("FAIL press_hold: held=%b column=%b, want held=1 column=101", key_held, column);
        end
        n_checks++;
        if (mm !== 0) begin n_fail++; $display("FAIL press_model: %0d mismatching cycles, want 0", mm); end
    endtask

    task automatic test_release();
        int p, mm, f, l, d; logic [3:0] c;
        hold(4'b0000, 14, p, c, mm, f, l, d);
        n_checks++;
        if (p !== 0 || key_held !== 1'b0 || column !== 3'b011) begin
            n_fail++;
            $display("FAIL release: pulses=%0d held=%b column=%b, want 0 pulses held=0 column=011", p, key_held, column);
        end
        n_checks++;
        if (mm !== 0) begin n_fail++; $display("FAIL release_model: %0d mismatching cycles, want 0", mm); end
    endtask

    task automatic test_bounce();
        bit ok; int p1, p2, mm1, mm2, f, l, d; logic [3:0] c;
        wait_col(3'b110, ok);
        hold(4'b1110, SCAN_DIV, p1, c, mm1, f, l, d);
        hold(4'b0000, 12, p2, c, mm2, f, l, d);
        n_checks++;
        if (!ok || p1 + p2 !== 0 || key_held !== 1'b0) begin
            n_fail++; $display("FAIL bounce_reject: ok=%0d pulses=%0d held=%b, want no event", ok, p1 + p2, key_held);
        end
        n_checks++;
        if (mm1 + mm2 !== 0) begin n_fail++; $display("FAIL bounce_model: %0d mismatching cycles, want 0", mm1 + mm2); end
        wait_col(3'b110, ok);
        hold(4'b1110, 20, p1, c, mm1, f, l, d);
        n_checks++;
        if (!ok || p1 !== 1 || c !== 4'hE) begin
            n_fail++; $display("FAIL bounce_star: ok=%0d pulses=%0d code=%h, want 1 pulse code=E", ok, p1, c);
        end
        hold(4'b0000, 16, p2, c, mm2, f, l, d);
        n_checks++;
        if (p2 !== 0 || key_held !== 1'b0 || mm1 + mm2 !== 0) begin
            n_fail++; $display("FAIL bounce_release: pulses=%0d held=%b mism=%0d, want 0/0/0", p2, key_held, mm1 + mm2);
        end
    endtask

    task automatic test_invalid();
        int p1, p2, mm1, mm2, f, l, d; logic [3:0] c;
        hold(4'b0011, 20 * SCAN_DIV, p1, c, mm1, f, l, d);
        n_checks++;
        if (p1 !== 0 || key_held !== 1'b0) begin
            n_fail++; $display("FAIL invalid_0011: pulses=%0d held=%b, want 0/0", p1, key_held);
        end
        hold(4'b1111, 20 * SCAN_DIV, p2, c, mm2, f, l, d);
        n_checks++;
        if (p2 !== 0 || key_held !== 1'b0) begin
            n_fail++; $display("FAIL invalid_1111: pulses=%0d held=%b, want 0/0", p2, key_held);
        end
        n_checks++;
        if (mm1 + mm2 !== 0) begin n_fail++; $display("FAIL invalid_model: %0d mismatching cycles, want 0", mm1 + mm2); end
    endtask

    task automatic test_repeat();
        bit ok; int p, mm, f, l, d, p2, mm2; logic [3:0] c;
        wait_col(3'b011, ok);
        hold(4'b1011, 30 * SCAN_DIV, p, c, mm, f, l, d);
        n_checks++;
        if (!ok || p !== EXP_REP_PULSES || c !== 4'h6) begin
            n_fail++; $display("FAIL repeat_count: ok=%0d pulses=%0d code=%h, want %0d pulses code=6",
                               ok, p, c, EXP_REP_PULSES);
        end
        n_checks++;
        if (l - f !== EXP_REP_SPAN || d !== 0) begin
            n_fail++; $display("FAIL repeat_spacing: span=%0d back_to_back=%0d, want %0d/0", l - f, d, EXP_REP_SPAN);
        end
        hold(4'b0000, 16, p2, c, mm2, f, l, d);
        n_checks++;
        if (p2 !== 0 || mm + mm2 !== 0) begin
            n_fail++; $display("FAIL repeat_release: pulses=%0d mism=%0d, want 0/0", p2, mm + mm2);
        end
    endtask

    task automatic test_mid_reset();
        bit ok; int p, mm, f, l, d; logic [3:0] c;
        wait_col(3'b101, ok);
        hold(4'b1101, 2 * SCAN_DIV, p, c, mm, f, l, d);
        rst = 1'b0;
        #1;
        n_checks++;
        if (!ok || p !== 0 || key_valid !== 1'b0 || column !== 3'b110 || key_code !== 4'h0 || key_held !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: pulses=%0d valid=%b col=%b code=%h held=%b, want 0/0/110/0/0",
                               p, key_valid, column, key_code, key_held);
        end
        repeat (3) @(negedge clk);
        row = 4'b0000;
        rst = 1'b1;
        hold(4'b0000, 4 * SCAN_DIV, p, c, mm, f, l, d);
        n_checks++;
        if (p !== 0 || mm !== 0) begin
            n_fail++; $display("FAIL mid_reset_resume: pulses=%0d mism=%0d, want 0/0", p, mm);
        end
    endtask

    task automatic test_random();
        int p, mm, f, l, d, sel, total_p, total_d;
        logic [3:0] c, pat;
        total_p = 0; total_d = 0;
        for (int s = 0; s < 80; s++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5) begin
                pat = 4'b1111;
                pat[$urandom_range(0, 3)] = 1'b0;
            end else if (sel < 7) begin
                pat = (sel == 5) ? 4'b0000 : 4'b1111;
            end else begin
                pat = 4'($urandom_range(0, 15));
            end
            hold(pat, $urandom_range(2, 60), p, c, mm, f, l, d);
            total_p += p; total_d += d;
            n_checks++;
            if (mm !== 0) begin
                n_fail++; $display("FAIL random_seg %0d row=%b: %0d mismatching cycles, want 0", s, pat, mm);
            end
        end
        n_checks++;
        if (total_d !== 0) begin
            n_fail++; $display("FAIL random_back_to_back: %0d consecutive key_valid cycles, want 0", total_d);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        row = 4'b0000;
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_invalid();
        test_repeat();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
